// File: rtl/dec_deserializer_22b.sv
// dec_deserializer_22b
// Receive side of the decimation filter's serial output link. Samples the
// serial bit and frame-sync strobe, rebuilds each MSB-first word, checks the
// frame length and presents committed words through a valid/ready handshake.
module dec_deserializer_22b #(
  parameter int DATA_W = 22,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              ser_data_i,
  input  logic              frame_sync_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              len_err_o,
  output logic              ovf_err_o,
  input  logic              err_clr_i,
  output logic              busy_o,
  output logic [CNT_W-1:0]  frame_cnt_o
);

  localparam int BCNT_W = $clog2(DATA_W + 1);
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_END, S_DRAIN} state_t;

  state_t              r_state;
  logic [BCNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]   r_shreg;
  logic                r_busy;

  logic                r_data_p0;
  logic                r_sync_p0;
  logic                r_sync_p1;
  logic                r_vld_p0;
  logic                r_vld_p1;

  logic [DATA_W-1:0]   r_data;
  logic                r_valid;
  logic                r_len_err;
  logic                r_ovf_err;
  logic [CNT_W-1:0]    r_frame_cnt;

  logic                w_rise;
  logic                w_held;
  logic                w_commit;
  logic                w_len_evt;
  logic                w_accept;
  logic                w_drop;

  // ---- stage p0/p1: input capture and sync edge history ----
  // r_vld_pN marks that the matching sample is a real observation rather than
  // a reset value, so a strobe already high when reset lifts is never taken
  // for a fresh frame start.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_data_p0 <= 1'b0;
      r_sync_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
      r_vld_p0  <= 1'b0;
      r_vld_p1  <= 1'b0;
    end else begin
      r_data_p0 <= ser_data_i;
      r_sync_p0 <= frame_sync_i;
      r_sync_p1 <= r_sync_p0;
      r_vld_p0  <= 1'b1;
      r_vld_p1  <= r_vld_p0;
    end
  end

  // ---- stage p2: frame FSM and output decode ----
  // Decode frame start, mid-frame entry, commit and length-error events.
  always_comb begin
    w_rise    = r_vld_p0 & r_vld_p1 & r_sync_p0 & ~r_sync_p1;
    w_held    = r_vld_p0 & r_sync_p0 & (r_sync_p1 | ~r_vld_p1);
    w_commit  = (r_state == S_END) & ~r_sync_p0;
    w_len_evt = ((r_state == S_SHIFT) & ~r_sync_p0) |
                ((r_state == S_END)   &  r_sync_p0);
    w_accept  = w_commit & (~r_valid | ready_i);
    w_drop    = w_commit & r_valid & ~ready_i;
  end

  // Frame FSM: shifts bits while sync is high and checks the frame length.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shreg <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_shreg <= {r_shreg[DATA_W-2:0], r_data_p0};
            r_cnt   <= BCNT_W'(1);
            r_state <= S_SHIFT;
            r_busy  <= 1'b1;
          end else if (w_held) begin
            r_state <= S_DRAIN;
            r_busy  <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (r_sync_p0) begin
            r_shreg <= {r_shreg[DATA_W-2:0], r_data_p0};
            r_cnt   <= r_cnt + BCNT_W'(1);
            if (r_cnt == LAST_BIT) begin
              r_state <= S_END;
            end
          end else begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_END: begin
          r_cnt <= '0;
          if (r_sync_p0) begin
            r_state <= S_DRAIN;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (!r_sync_p0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output word, handshake, sticky error flags and committed-frame counter.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_len_err   <= 1'b0;
      r_ovf_err   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_data      <= r_shreg;
        r_valid     <= 1'b1;
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      end else if (r_valid && ready_i) begin
        r_valid <= 1'b0;
      end
      // A set event on the same edge takes priority over a clear.
      if (w_len_evt) begin
        r_len_err <= 1'b1;
      end else if (err_clr_i) begin
        r_len_err <= 1'b0;
      end
      if (w_drop) begin
        r_ovf_err <= 1'b1;
      end else if (err_clr_i) begin
        r_ovf_err <= 1'b0;
      end
    end
  end

  assign data_o      = r_data;
  assign valid_o     = r_valid;
  assign len_err_o   = r_len_err;
  assign ovf_err_o   = r_ovf_err;
  assign busy_o      = r_busy;
  assign frame_cnt_o = r_frame_cnt;

endmodule

// File: tb/tb_dec_deserializer_22b.sv
// Directed testbench for dec_deserializer_22b. A second instance with a
// 4-bit frame counter shares all inputs so counter wrap is reachable quickly.
module tb_dec_deserializer_22b;

  localparam int DW = 22;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          ser_data_i;
  logic          frame_sync_i;
  logic          ready_i;
  logic          err_clr_i;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          len_err_o;
  logic          ovf_err_o;
  logic          busy_o;
  logic [15:0]   frame_cnt_o;
  logic [DW-1:0] data_w;
  logic          valid_w;
  logic          len_w;
  logic          ovf_w;
  logic          busy_w;
  logic [3:0]    frame_cnt_w;

  int errors = 0;
  int checks = 0;

  dec_deserializer_22b #(.DATA_W(DW), .CNT_W(16)) dut (
    .clk(clk), .rst_b(rst_b), .ser_data_i(ser_data_i), .frame_sync_i(frame_sync_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .len_err_o(len_err_o),
    .ovf_err_o(ovf_err_o), .err_clr_i(err_clr_i), .busy_o(busy_o),
    .frame_cnt_o(frame_cnt_o)
  );

  dec_deserializer_22b #(.DATA_W(DW), .CNT_W(4)) dut_w (
    .clk(clk), .rst_b(rst_b), .ser_data_i(ser_data_i), .frame_sync_i(frame_sync_i),
    .data_o(data_w), .valid_o(valid_w), .ready_i(ready_i), .len_err_o(len_w),
    .ovf_err_o(ovf_w), .err_clr_i(err_clr_i), .busy_o(busy_w),
    .frame_cnt_o(frame_cnt_w)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, then observe outputs 1 time unit after the edge.
  task automatic step(input logic s, input logic d);
    frame_sync_i = s;
    ser_data_i   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    step(1'b0, 1'b0);
    rst_b = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  // Sync high for n cycles carrying w MSB first (zero bits beyond DW).
  task automatic send_frame(input logic [DW-1:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, (i < DW) ? w[DW-1-i] : 1'b0);
    end
  endtask

  task automatic test_reset();
    rst_b = 1'b0; ready_i = 1'b1; err_clr_i = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    if (data_o !== 22'h0) begin errors++; $display("FAIL reset_data: got %h want 0", data_o); end
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    checks++;
    if (len_err_o !== 1'b0) begin errors++; $display("FAIL reset_len: got %b want 0", len_err_o); end
    checks++;
    if (ovf_err_o !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf_err_o); end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    checks++;
    if (frame_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", frame_cnt_o); end
    checks++;
    rst_b = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic test_basic();
    do_reset();
    ready_i = 1'b1;
    send_frame(22'h2A5A5A, DW);                  // edges 0..21
    if (busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy_o); end
    checks++;
    step(1'b0, 1'b0);                            // edge 22
    if (valid_o !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want 0", valid_o); end
    checks++;
    step(1'b0, 1'b0);                            // edge 23: commit
    if ({valid_o, data_o} !== {1'b1, 22'h2A5A5A}) begin
      errors++; $display("FAIL basic_word: got v=%b d=%h want v=1 d=2a5a5a", valid_o, data_o);
    end
    checks++;
    if (frame_cnt_o !== 16'd1) begin errors++; $display("FAIL basic_cnt: got %0d want 1", frame_cnt_o); end
    checks++;
    if ({len_err_o, ovf_err_o, busy_o} !== 3'b000) begin
      errors++; $display("FAIL basic_flags: got len=%b ovf=%b busy=%b want 000", len_err_o, ovf_err_o, busy_o);
    end
    checks++;
    step(1'b0, 1'b0);                            // edge 24: consumed
    if ({valid_o, data_o} !== {1'b0, 22'h2A5A5A}) begin
      errors++; $display("FAIL basic_consumed: got v=%b d=%h want v=0 d=2a5a5a", valid_o, data_o);
    end
    checks++;
  endtask

  task automatic test_short();
    do_reset();
    ready_i = 1'b1;
    send_frame(22'h155555, 10);                  // edges 0..9
    step(1'b0, 1'b0);                            // edge 10 samples the drop
    if (len_err_o !== 1'b0) begin errors++; $display("FAIL short_len_early: got %b want 0", len_err_o); end
    checks++;
    err_clr_i = 1'b1;                            // clear on the same edge as the set
    step(1'b0, 1'b0);                            // edge 11
    err_clr_i = 1'b0;
    if (len_err_o !== 1'b1) begin errors++; $display("FAIL short_len_set: got %b want 1", len_err_o); end
    checks++;
    if ({valid_o, busy_o} !== 2'b00) begin
      errors++; $display("FAIL short_idle: got valid=%b busy=%b want 00", valid_o, busy_o);
    end
    checks++;
    if (frame_cnt_o !== 16'd0) begin errors++; $display("FAIL short_cnt: got %0d want 0", frame_cnt_o); end
    checks++;
    send_frame(22'h3FFFFF, DW);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    if ({valid_o, data_o} !== {1'b1, 22'h3FFFFF}) begin
      errors++; $display("FAIL short_next_word: got v=%b d=%h want v=1 d=3fffff", valid_o, data_o);
    end
    checks++;
    if (frame_cnt_o !== 16'd1) begin errors++; $display("FAIL short_next_cnt: got %0d want 1", frame_cnt_o); end
    checks++;
  endtask

  task automatic test_long();
    do_reset();
    ready_i = 1'b1;
    send_frame(22'h123456, 25);                  // edges 0..24
    if ({len_err_o, busy_o, valid_o} !== 3'b110) begin
      errors++; $display("FAIL long_flags: got len=%b busy=%b valid=%b want 110", len_err_o, busy_o, valid_o);
    end
    checks++;
    step(1'b0, 1'b0);                            // edge 25: still draining
    if (busy_o !== 1'b1) begin errors++; $display("FAIL long_drain: got %b want 1", busy_o); end
    checks++;
    step(1'b0, 1'b0);                            // edge 26: back to idle
    if (busy_o !== 1'b0) begin errors++; $display("FAIL long_idle: got %b want 0", busy_o); end
    checks++;
    if (frame_cnt_o !== 16'd0) begin errors++; $display("FAIL long_cnt: got %0d want 0", frame_cnt_o); end
    checks++;
    err_clr_i = 1'b1;
    step(1'b0, 1'b0);
    err_clr_i = 1'b0;
    if (len_err_o !== 1'b0) begin errors++; $display("FAIL long_clr: got %b want 0", len_err_o); end
    checks++;
  endtask

  task automatic test_overflow();
    do_reset();
    ready_i = 1'b0;
    send_frame(22'h000001, DW);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    if ({valid_o, data_o} !== {1'b1, 22'h000001}) begin
      errors++; $display("FAIL ovf_first: got v=%b d=%h want v=1 d=000001", valid_o, data_o);
    end
    checks++;
    step(1'b0, 1'b0);
    send_frame(22'h155555, DW);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);                            // commit attempt is dropped
    if ({valid_o, data_o} !== {1'b1, 22'h000001}) begin
      errors++; $display("FAIL ovf_hold: got v=%b d=%h want v=1 d=000001", valid_o, data_o);
    end
    checks++;
    if (ovf_err_o !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", ovf_err_o); end
    checks++;
    if (frame_cnt_o !== 16'd1) begin errors++; $display("FAIL ovf_cnt: got %0d want 1", frame_cnt_o); end
    checks++;
    ready_i = 1'b1;
    step(1'b0, 1'b0);
    if (valid_o !== 1'b0) begin errors++; $display("FAIL ovf_consume: got %b want 0", valid_o); end
    checks++;
    err_clr_i = 1'b1;
    step(1'b0, 1'b0);
    err_clr_i = 1'b0;
    if (ovf_err_o !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b want 0", ovf_err_o); end
    checks++;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] w;
    logic [DW-1:0] prev;
    do_reset();
    ready_i = 1'b1;
    prev = '0;
    for (int f = 0; f < 300; f++) begin
      w = DW'((32'(f) * 32'h0002F1D3) ^ 32'h0002A5A5);
      for (int b = 0; b < DW; b++) begin
        step(1'b1, w[DW-1-b]);
        // The previous frame commits on the first bit edge of this one.
        if (b == 0 && f > 0) begin
          if ({valid_o, data_o} !== {1'b1, prev}) begin
            errors++; $display("FAIL b2b_word[%0d]: got v=%b d=%h want v=1 d=%h", f - 1, valid_o, data_o, prev);
          end
          checks++;
          if (f == 16) begin
            if ({frame_cnt_w, frame_cnt_o} !== {4'd0, 16'd16}) begin
              errors++; $display("FAIL b2b_wrap: got small=%0d big=%0d want 0 16", frame_cnt_w, frame_cnt_o);
            end
            checks++;
          end
        end
      end
      step(1'b0, 1'b0);                          // single low gap cycle
      prev = w;
    end
    step(1'b0, 1'b0);
    if ({valid_o, data_o} !== {1'b1, prev}) begin
      errors++; $display("FAIL b2b_last: got v=%b d=%h want v=1 d=%h", valid_o, data_o, prev);
    end
    checks++;
    if (frame_cnt_o !== 16'd300) begin errors++; $display("FAIL b2b_cnt: got %0d want 300", frame_cnt_o); end
    checks++;
    if (frame_cnt_w !== 4'd12) begin errors++; $display("FAIL b2b_small_cnt: got %0d want 12", frame_cnt_w); end
    checks++;
    if ({len_err_o, ovf_err_o} !== 2'b00) begin
      errors++; $display("FAIL b2b_flags: got len=%b ovf=%b want 00", len_err_o, ovf_err_o);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] w;
    do_reset();
    ready_i = 1'b0;
    send_frame(22'h2A5A5A, DW);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    w = 22'h1ABCDE;
    for (int b = 0; b < 11; b++) step(1'b1, w[DW-1-b]);
    if ({busy_o, valid_o, frame_cnt_o} !== {1'b1, 1'b1, 16'd1}) begin
      errors++; $display("FAIL mid_pre: got busy=%b valid=%b cnt=%0d want 1 1 1", busy_o, valid_o, frame_cnt_o);
    end
    checks++;
    rst_b = 1'b0;
    step(1'b1, w[DW-1-11]);                      // reset lands on bit 11
    rst_b = 1'b1;
    if ({data_o, valid_o, busy_o, len_err_o, ovf_err_o, frame_cnt_o} !== '0) begin
      errors++; $display("FAIL mid_reset: got d=%h v=%b busy=%b len=%b ovf=%b cnt=%0d want all 0",
                         data_o, valid_o, busy_o, len_err_o, ovf_err_o, frame_cnt_o);
    end
    checks++;
    ready_i = 1'b1;
    step(1'b1, w[DW-1-12]);
    step(1'b1, w[DW-1-13]);
    if (busy_o !== 1'b1) begin errors++; $display("FAIL mid_drain: got %b want 1", busy_o); end
    checks++;
    for (int b = 14; b < DW; b++) step(1'b1, w[DW-1-b]);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    if ({busy_o, len_err_o, valid_o} !== 3'b000) begin
      errors++; $display("FAIL mid_quiet: got busy=%b len=%b valid=%b want 000", busy_o, len_err_o, valid_o);
    end
    checks++;
    send_frame(22'h2BCDEF, DW);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    if ({valid_o, data_o, frame_cnt_o} !== {1'b1, 22'h2BCDEF, 16'd1}) begin
      errors++; $display("FAIL mid_next: got v=%b d=%h cnt=%0d want 1 2bcdef 1", valid_o, data_o, frame_cnt_o);
    end
    checks++;
  endtask

  initial begin
    rst_b = 1'b0; ser_data_i = 1'b0; frame_sync_i = 1'b0;
    ready_i = 1'b1; err_clr_i = 1'b0;
    test_reset();
    test_basic();
    test_short();
    test_long();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
